irq_ctrl: RTL and testbench

- Parametrised interrupt controller that generalises the SoC's fixed three-line interrupt set to NUM_IRQ sources.
- Per source: enable, edge/level mode, pending and in-service tracking.
- Fixed priority, with a claim/complete handshake through a simple register port.
- Sits between SoC peripherals (UART, GPIO, timers) and the core's single external interrupt input; software reaches it through a bus-to-reg bridge off the AXI crossbar.

---
 rtl/irq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_irq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Parametrised fixed-priority interrupt controller.
// Each source is synchronised, optionally edge-detected, and tracked through
// pending / in-service state. Software claims the highest-priority enabled
// pending source by reading CLAIM and completes it by writing the ID back.
module irq_ctrl #(
    parameter int NUM_IRQ     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               reg_req_i,
    input  logic               reg_we_i,
    input  logic [7:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic               reg_gnt_o,
    output logic               reg_rvalid_o,
    output logic [31:0]        reg_rdata_o,
    output logic               reg_err_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o
);

    localparam logic [5:0] ADDR_PENDING   = 6'h00;
    localparam logic [5:0] ADDR_ENABLE    = 6'h01;
    localparam logic [5:0] ADDR_MODE      = 6'h02;
    localparam logic [5:0] ADDR_INSERVICE = 6'h03;
    localparam logic [5:0] ADDR_CLAIM     = 6'h04;
    localparam logic [5:0] ADDR_INFO      = 6'h05;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] sync_d_q;
    logic [NUM_IRQ-1:0] rise;

    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] inservice_q, inservice_d;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] claim_mask;
    logic [NUM_IRQ-1:0] claim_clr;
    logic [NUM_IRQ-1:0] complete_mask;
    logic [NUM_IRQ-1:0] set_mask;
    logic [4:0]         claim_id;

    logic [5:0]  word;
    logic        claim_rd;
    logic        complete_wr;
    logic [31:0] rdata_d;
    logic        err_d;

    logic        irq_q;
    logic [4:0]  irq_id_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // The two low address bits select a byte within a word and are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^reg_addr_i[1:0];

    // Every request is accepted immediately, so grant simply mirrors request.
    assign reg_gnt_o = reg_req_i;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~sync_d_q;
    assign active = pending_q & enable_q;
    assign word   = reg_addr_i[7:2];

    // Metastability synchroniser chain plus one extra delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            sync_d_q <= '0;
        end else begin
            sync_q[0] <= irq_src_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            sync_d_q <= sync_s;
        end
    end

    // Fixed priority: the lowest index wins, so scan downwards and let lower indices overwrite.
    always_comb begin
        claim_id   = '0;
        claim_mask = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_id      = 5'(i + 1);
                claim_mask    = '0;
                claim_mask[i] = 1'b1;
            end
        end
    end

    // Register decode: read data, error flag, RW register updates and claim/complete strobes.
    always_comb begin
        rdata_d     = '0;
        err_d       = 1'b0;
        enable_d    = enable_q;
        mode_d      = mode_q;
        claim_rd    = 1'b0;
        complete_wr = 1'b0;
        if (reg_req_i) begin
            case (word)
                ADDR_PENDING: begin
                    if (reg_we_i) err_d = 1'b1;
                    else          rdata_d = 32'(pending_q);
                end
                ADDR_ENABLE: begin
                    if (reg_we_i) enable_d = reg_wdata_i[NUM_IRQ-1:0];
                    else          rdata_d = 32'(enable_q);
                end
                ADDR_MODE: begin
                    if (reg_we_i) mode_d = reg_wdata_i[NUM_IRQ-1:0];
                    else          rdata_d = 32'(mode_q);
                end
                ADDR_INSERVICE: begin
                    if (reg_we_i) err_d = 1'b1;
                    else          rdata_d = 32'(inservice_q);
                end
                ADDR_CLAIM: begin
                    if (reg_we_i) begin
                        complete_wr = 1'b1;
                    end else begin
                        claim_rd = 1'b1;
                        rdata_d  = 32'(claim_id);
                    end
                end
                ADDR_INFO: begin
                    if (reg_we_i) err_d = 1'b1;
                    else          rdata_d = 32'(NUM_IRQ);
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Next pending/in-service state; a new set beats a claim clear, and level
    // sources look at the post-claim in-service value so a claim cannot re-pend itself.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            complete_mask[i] = complete_wr && (reg_wdata_i == 32'(i + 1));
        end
        claim_clr   = claim_rd ? claim_mask : '0;
        inservice_d = (inservice_q | claim_clr) & ~complete_mask;
        set_mask    = (mode_q & rise) | (~mode_q & sync_s & ~inservice_d);
        pending_d   = set_mask | (pending_q & ~claim_clr);
    end

    // Controller state and registered interrupt outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pending_q   <= '0;
            inservice_q <= '0;
            irq_q       <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            irq_q       <= |active;
            irq_id_q    <= claim_id;
        end
    end

    // Register response appears one cycle after the accepting edge and lasts one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= reg_req_i;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_err_o    = err_q;
    assign irq_o        = irq_q;
    assign irq_id_o     = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl with the default three sources.
module tb_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [2:0]  irq_src_i;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [7:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        reg_gnt_o;
    logic        reg_rvalid_o;
    logic [31:0] reg_rdata_o;
    logic        reg_err_o;
    logic        irq_o;
    logic [4:0]  irq_id_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rd;
    logic        er, vl, gn;

    irq_ctrl #(.NUM_IRQ(3), .SYNC_STAGES(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .irq_src_i    (irq_src_i),
        .reg_req_i    (reg_req_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_gnt_o    (reg_gnt_o),
        .reg_rvalid_o (reg_rvalid_o),
        .reg_rdata_o  (reg_rdata_o),
        .reg_err_o    (reg_err_o),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    // One register access, started at a falling edge; response sampled at the next falling edge.
    task automatic reg_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output logic valid,
                              output logic gnt);
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        #1 gnt = reg_gnt_o;
        @(negedge clk_i);
        valid = reg_rvalid_o;
        rdata = reg_rdata_o;
        err   = reg_err_o;
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; irq_src_i = '0; reg_req_i = 1'b0; reg_we_i = 1'b0;
        reg_addr_i = '0; reg_wdata_i = '0;
        #12;
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        n_cmp++; if (irq_id_o !== 5'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", irq_id_o); end
        n_cmp++; if (reg_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", reg_rvalid_o); end
        n_cmp++; if (reg_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", reg_rdata_o); end
        n_cmp++; if (reg_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", reg_err_o); end
        n_cmp++; if (reg_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", reg_gnt_o); end
        @(negedge clk_i); rst_ni = 1'b1; @(negedge clk_i);
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL reset_pending_err: got %b expected 0", er); end
        n_cmp++; if (vl !== 1'b1) begin n_fail++; $display("FAIL reset_rvalid_resp: got %b expected 1", vl); end
        n_cmp++; if (gn !== 1'b1) begin n_fail++; $display("FAIL reset_gnt_req: got %b expected 1", gn); end
        reg_access(1'b0, 8'h04, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_enable: got %h expected 0", rd); end
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_inservice: got %h expected 0", rd); end
        reg_access(1'b0, 8'h14, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL reset_info: got %h expected 3", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL reset_info_err: got %b expected 0", er); end
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after: got %b expected 0", irq_o); end
    endtask

    task automatic test_edge;
        reg_access(1'b1, 8'h04, 32'h7, rd, er, vl, gn);
        n_cmp++; if (er !== 1'b0 || vl !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL edge_wr_enable: got err=%b valid=%b rdata=%h expected 0/1/0", er, vl, rd); end
        reg_access(1'b1, 8'h08, 32'h7, rd, er, vl, gn);
        reg_access(1'b0, 8'h08, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL edge_mode_rb: got %h expected 7", rd); end
        irq_src_i[1] = 1'b1; @(negedge clk_i); irq_src_i[1] = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL edge_latency_early: got %b expected 0", irq_o); end
        @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL edge_latency: got %b expected 1", irq_o); end
        n_cmp++; if (irq_id_o !== 5'd2) begin n_fail++; $display("FAIL edge_id: got %0d expected 2", irq_id_o); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd2) begin n_fail++; $display("FAIL edge_claim: got %h expected 2", rd); end
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL edge_pending_after: got %h expected 0", rd); end
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL edge_irq_drop: got %b expected 0", irq_o); end
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL edge_inservice: got %h expected 2", rd); end
        reg_access(1'b1, 8'h10, 32'd2, rd, er, vl, gn);
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL edge_complete: got %h expected 0", rd); end
    endtask

    task automatic test_priority;
        irq_src_i = 3'b101; @(negedge clk_i); irq_src_i = 3'b000;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin n_fail++; $display("FAIL prio_irq: got irq=%b id=%0d expected 1/1", irq_o, irq_id_o); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL prio_claim1: got %h expected 1", rd); end
        @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd3) begin n_fail++; $display("FAIL prio_stay_high: got irq=%b id=%0d expected 1/3", irq_o, irq_id_o); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL prio_claim2: got %h expected 3", rd); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL prio_claim3: got %h err=%b expected 0/0", rd, er); end
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL prio_inservice: got %h expected 5", rd); end
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL prio_irq_low: got %b expected 0", irq_o); end
        reg_access(1'b1, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL prio_complete0_err: got %b expected 0", er); end
        reg_access(1'b1, 8'h10, 32'd4, rd, er, vl, gn);
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL prio_complete4_err: got %b expected 0", er); end
        reg_access(1'b1, 8'h10, 32'h21, rd, er, vl, gn);
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL prio_bad_complete: got %h expected 5", rd); end
        reg_access(1'b1, 8'h10, 32'd1, rd, er, vl, gn);
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL prio_complete1: got %h expected 4", rd); end
        reg_access(1'b1, 8'h10, 32'd3, rd, er, vl, gn);
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL prio_complete3: got %h expected 0", rd); end
    endtask

    task automatic test_level;
        reg_access(1'b1, 8'h08, 32'h0, rd, er, vl, gn);
        irq_src_i[0] = 1'b1;
        repeat (4) @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin n_fail++; $display("FAIL level_irq: got irq=%b id=%0d expected 1/1", irq_o, irq_id_o); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL level_claim: got %h expected 1", rd); end
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL level_no_repend: got %h expected 0", rd); end
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL level_irq_drop: got %b expected 0", irq_o); end
        reg_access(1'b1, 8'h10, 32'd1, rd, er, vl, gn);
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL level_repend: got %h expected 1", rd); end
        n_cmp++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL level_irq_again: got %b expected 1", irq_o); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL level_claim2: got %h expected 1", rd); end
        irq_src_i[0] = 1'b0;
        repeat (3) @(negedge clk_i);
        reg_access(1'b1, 8'h10, 32'd1, rd, er, vl, gn);
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL level_released: got %h expected 0", rd); end
        @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL level_irq_released: got %b expected 0", irq_o); end
    endtask

    task automatic test_simultaneous;
        reg_access(1'b1, 8'h08, 32'h7, rd, er, vl, gn);
        irq_src_i[2] = 1'b1; @(negedge clk_i); irq_src_i[2] = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd3) begin n_fail++; $display("FAIL simul_irq: got irq=%b id=%0d expected 1/3", irq_o, irq_id_o); end
        irq_src_i[2] = 1'b1; @(negedge clk_i); irq_src_i[2] = 1'b0;
        @(negedge clk_i);
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL simul_claim: got %h expected 3", rd); end
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL simul_pending: got %h expected 4", rd); end
        reg_access(1'b0, 8'h0C, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL simul_inservice: got %h expected 4", rd); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL simul_claim2: got %h expected 3", rd); end
        reg_access(1'b1, 8'h10, 32'd3, rd, er, vl, gn);
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL simul_pending_clr: got %h expected 0", rd); end
    endtask

    task automatic test_errors;
        reg_access(1'b1, 8'h00, 32'h7, rd, er, vl, gn);
        n_cmp++; if (er !== 1'b1 || vl !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_wr_pending: got err=%b valid=%b rdata=%h expected 1/1/0", er, vl, rd); end
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL err_pending_kept: got %h err=%b expected 0/0", rd, er); end
        reg_access(1'b0, 8'h20, 32'd0, rd, er, vl, gn);
        n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_rd_0x20: got err=%b rdata=%h expected 1/0", er, rd); end
        reg_access(1'b1, 8'h18, 32'hFF, rd, er, vl, gn);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_wr_0x18: got %b expected 1", er); end
        reg_access(1'b1, 8'h0C, 32'h7, rd, er, vl, gn);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_wr_inservice: got %b expected 1", er); end
        reg_access(1'b1, 8'h04, 32'hFFFF_FFFF, rd, er, vl, gn);
        reg_access(1'b0, 8'h04, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL err_enable_mask: got %h expected 7", rd); end
        reg_access(1'b0, 8'h08, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h7) begin n_fail++; $display("FAIL err_mode_kept: got %h expected 7", rd); end
        reg_access(1'b1, 8'h04, 32'h0, rd, er, vl, gn);
        irq_src_i[1] = 1'b1; @(negedge clk_i); irq_src_i[1] = 1'b0;
        repeat (4) @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL mask_irq: got %b expected 0", irq_o); end
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL mask_pending: got %h expected 2", rd); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL mask_claim: got %h expected 0", rd); end
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL mask_pending_kept: got %h expected 2", rd); end
        reg_access(1'b1, 8'h04, 32'h2, rd, er, vl, gn);
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL mask_enable_early: got %b expected 0", irq_o); end
        @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd2) begin n_fail++; $display("FAIL mask_enable_irq: got irq=%b id=%0d expected 1/2", irq_o, irq_id_o); end
    endtask

    task automatic test_mode_change;
        reg_access(1'b1, 8'h08, 32'h0, rd, er, vl, gn);
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL mode_pending_kept: got %h expected 2", rd); end
        reg_access(1'b0, 8'h10, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'd2) begin n_fail++; $display("FAIL mode_claim: got %h expected 2", rd); end
        reg_access(1'b1, 8'h10, 32'd2, rd, er, vl, gn);
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mode_pending_clr: got %h expected 0", rd); end
        reg_access(1'b1, 8'h08, 32'h7, rd, er, vl, gn);
    endtask

    task automatic test_back_to_back;
        reg_access(1'b1, 8'h04, 32'h5, rd, er, vl, gn);
        reg_access(1'b0, 8'h04, 32'd0, rd, er, vl, gn);
        n_cmp++; if (vl !== 1'b1 || rd !== 32'h5) begin n_fail++; $display("FAIL b2b_enable: got valid=%b rdata=%h expected 1/5", vl, rd); end
        reg_access(1'b0, 8'h08, 32'd0, rd, er, vl, gn);
        n_cmp++; if (vl !== 1'b1 || rd !== 32'h7) begin n_fail++; $display("FAIL b2b_mode: got valid=%b rdata=%h expected 1/7", vl, rd); end
        reg_access(1'b0, 8'h14, 32'd0, rd, er, vl, gn);
        n_cmp++; if (vl !== 1'b1 || rd !== 32'h3) begin n_fail++; $display("FAIL b2b_info: got valid=%b rdata=%h expected 1/3", vl, rd); end
        @(negedge clk_i);
        n_cmp++; if (reg_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_end: got %b expected 0", reg_rvalid_o); end
    endtask

    task automatic test_reset_mid;
        irq_src_i[0] = 1'b1; @(negedge clk_i); irq_src_i[0] = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin n_fail++; $display("FAIL rstmid_irq: got irq=%b id=%0d expected 1/1", irq_o, irq_id_o); end
        reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 8'h04;
        @(posedge clk_i); #2;
        n_cmp++; if (reg_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_rvalid_pre: got %b expected 1", reg_rvalid_o); end
        rst_ni = 1'b0; reg_req_i = 1'b0; reg_addr_i = '0;
        #1;
        n_cmp++; if (reg_rvalid_o !== 1'b0 || irq_o !== 1'b0 || irq_id_o !== 5'd0) begin n_fail++; $display("FAIL rstmid_clear: got rvalid=%b irq=%b id=%0d expected 0/0/0", reg_rvalid_o, irq_o, irq_id_o); end
        @(negedge clk_i); rst_ni = 1'b1; @(negedge clk_i);
        reg_access(1'b0, 8'h04, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_enable: got %h expected 0", rd); end
        reg_access(1'b0, 8'h00, 32'd0, rd, er, vl, gn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_pending: got %h expected 0", rd); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset;
        test_edge;
        test_priority;
        test_level;
        test_simultaneous;
        test_errors;
        test_mode_change;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
